// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, threshold flags, fill count and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses registered reads.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            wr_en,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_accept;
    logic                  wr_accept;

    // Pointers wrap at FIFO_DEPTH-1 so non-power-of-two depths use every slot.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CW'(AF_THRESH)) && !full;
    assign almostempty = (count <= CW'(AE_THRESH)) && !empty;

    // A read that frees a slot lets a write proceed even when full.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty so reset shows zero.
    assign data_out  = empty ? '0 : mem[rd_ptr];
    assign valid_out = !empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else begin
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
            valid_out <= rd_accept;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a depth-6 instance for wrap/overflow and a depth-8
// instance (AF=5, AE=2) for thresholds, simultaneous access and flush. Both share stimulus.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] dout_a, dout_b;
    logic        valid_a, valid_b, ack_a, ack_b, ovf_a, ovf_b, unf_a, unf_b;
    logic        full_a, full_b, empty_a, empty_b, af_a, af_b, ae_a, ae_b;
    logic [2:0]  cnt_a;
    logic [3:0]  cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_a), .valid_out(valid_a), .wr_ack(ack_a), .overflow(ovf_a),
        .underflow(unf_a), .full(full_a), .empty(empty_a), .almostfull(af_a),
        .almostempty(ae_a), .count(cnt_a)
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(5), .AE_THRESH(2)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_b), .valid_out(valid_b), .wr_ack(ack_b), .overflow(ovf_b),
        .underflow(unf_b), .full(full_b), .empty(empty_b), .almostfull(af_b),
        .almostempty(ae_b), .count(cnt_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [15:0] d,
                                 input logic f);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        flush   = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    // Read one word and check it: in FWFT the head is visible before the pop,
    // otherwise the word appears on data_out after the read edge.
    task automatic xferCheck(input int inst, input logic w, input logic [15:0] d,
                             input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        checkOutput("head_data", 32'((inst == 0) ? dout_a : dout_b), 32'(exp));
        checkOutput("head_valid", 32'((inst == 0) ? valid_a : valid_b), 32'd1);
        applyStimulus(w, 1'b1, d, 1'b0);
`else
        applyStimulus(w, 1'b1, d, 1'b0);
        checkOutput("rd_data", 32'((inst == 0) ? dout_a : dout_b), 32'(exp));
        checkOutput("rd_valid", 32'((inst == 0) ? valid_a : valid_b), 32'd1);
`endif
    endtask

    initial begin
        logic [15:0] v;

        // Reset state on both instances
        doReset();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("rst_count_a", 32'(cnt_a), 32'd0);
        checkOutput("rst_empty_a", 32'(empty_a), 32'd1);
        checkOutput("rst_full_a", 32'(full_a), 32'd0);
        checkOutput("rst_count_b", 32'(cnt_b), 32'd0);
        checkOutput("rst_empty_b", 32'(empty_b), 32'd1);
        checkOutput("rst_flags_b", 32'({full_b, af_b, ae_b}), 32'd0);
        checkOutput("rst_pulses_b", 32'({ack_b, ovf_b, unf_b, valid_b}), 32'd0);
        checkOutput("rst_dout_b", 32'(dout_b), 32'd0);

        // Depth 6: offset pointers by one, then three full fill/drain rounds to wrap
        applyStimulus(1'b1, 1'b0, 16'h00FF, 1'b0);
        xferCheck(0, 1'b0, 16'h0, 16'h00FF);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                v = 16'((r + 1) * 16 + i + 1);
                applyStimulus(1'b1, 1'b0, v, 1'b0);
                checkOutput("a_wr_count", 32'(cnt_a), 32'(i + 1));
                checkOutput("a_wr_ack", 32'(ack_a), 32'd1);
            end
            checkOutput("a_full", 32'(full_a), 32'd1);
            applyStimulus(1'b1, 1'b0, 16'hDEAD, 1'b0);
            checkOutput("a_ovf", 32'(ovf_a), 32'd1);
            checkOutput("a_ovf_ack", 32'(ack_a), 32'd0);
            checkOutput("a_ovf_count", 32'(cnt_a), 32'd6);
            for (int i = 0; i < 6; i++) begin
                v = 16'((r + 1) * 16 + i + 1);
                xferCheck(0, 1'b0, 16'h0, v);
                checkOutput("a_rd_count", 32'(cnt_a), 32'(5 - i));
            end
            checkOutput("a_empty", 32'(empty_a), 32'd1);
        end

        // Depth 8 thresholds: fill 0 -> 8
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 16'(32'h100 + k), 1'b0);
            checkOutput("b_fill_count", 32'(cnt_b), 32'(k));
            checkOutput("b_ae", 32'(ae_b), 32'((k <= 2) ? 1 : 0));
            checkOutput("b_af", 32'(af_b), 32'((k >= 5 && k <= 7) ? 1 : 0));
            checkOutput("b_full", 32'(full_b), 32'((k == 8) ? 1 : 0));
        end

        // Full with simultaneous write and read
        xferCheck(1, 1'b1, 16'hA5A5, 16'h0101);
        checkOutput("b_both_full_count", 32'(cnt_b), 32'd8);
        checkOutput("b_both_full_ack", 32'(ack_b), 32'd1);
        checkOutput("b_both_full_ovf", 32'(ovf_b), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            xferCheck(1, 1'b0, 16'h0, 16'(32'h100 + k));
        end
        xferCheck(1, 1'b0, 16'h0, 16'hA5A5);
        checkOutput("b_drained_empty", 32'(empty_b), 32'd1);

        // Empty with simultaneous write and read
        applyStimulus(1'b1, 1'b1, 16'h0077, 1'b0);
        checkOutput("b_both_empty_count", 32'(cnt_b), 32'd1);
        checkOutput("b_both_empty_unf", 32'(unf_b), 32'd1);
        checkOutput("b_both_empty_ack", 32'(ack_b), 32'd1);
`ifdef FIFO_FWFT_EN
        checkOutput("b_both_empty_valid", 32'(valid_b), 32'd1);
`else
        checkOutput("b_both_empty_valid", 32'(valid_b), 32'd0);
`endif

        // Flush mid-stream with a write request in the same cycle
        doReset();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 16'(32'h200 + k), 1'b0);
        end
        xferCheck(1, 1'b0, 16'h0, 16'h0201);
        applyStimulus(1'b1, 1'b0, 16'h0999, 1'b1);
        checkOutput("flush_count", 32'(cnt_b), 32'd0);
        checkOutput("flush_empty", 32'(empty_b), 32'd1);
        checkOutput("flush_ack", 32'(ack_b), 32'd0);
        checkOutput("flush_valid", 32'(valid_b), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("flush_dout_hold", 32'(dout_b), 32'h0201);
`endif
        applyStimulus(1'b1, 1'b0, 16'h0042, 1'b0);
        checkOutput("post_flush_count", 32'(cnt_b), 32'd1);
        checkOutput("post_flush_ack", 32'(ack_b), 32'd1);
        xferCheck(1, 1'b0, 16'h0, 16'h0042);

        // Rejected read on empty
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0);
        checkOutput("unf_pulse", 32'(unf_b), 32'd1);
        checkOutput("unf_valid", 32'(valid_b), 32'd0);
        checkOutput("unf_count", 32'(cnt_b), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("unf_dout_hold", 32'(dout_b), 32'h0042);
`endif
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("idle_pulses", 32'({ack_b, ovf_b, unf_b}), 32'd0);

`ifdef FIFO_FWFT_EN
        // Head visible without a read request
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h1234, 1'b0);
        checkOutput("fwft_dout", 32'(dout_b), 32'h1234);
        checkOutput("fwft_valid", 32'(valid_b), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0);
        checkOutput("fwft_pop_empty", 32'(empty_b), 32'd1);
        checkOutput("fwft_pop_valid", 32'(valid_b), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with arbitrary (non-power-of-two) depth, parameter-set almost-full/almost-empty thresholds, a live fill count, a synchronous flush, and registered handshake/status pulses. It is the general-purpose buffering block for the datapath and replaces fixed-geometry FIFOs wherever width, depth or threshold must vary per instance. An optional first-word-fall-through read mode is selectable at compile time.

## Interface
- FIFO_WIDTH, 16, data width in bits (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, any integer)
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count ≥ AF_THRESH (1..FIFO_DEPTH-1)
- AE_THRESH, 1, almostempty asserts when count ≤ AE_THRESH (1..FIFO_DEPTH-1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high, highest priority
- flush  in  1  synchronous clear of contents; priority below rst
- wr_en  in  1  write request
- data_in  in  FIFO_WIDTH  write data
- rd_en  in  1  read request (pop acknowledge in FWFT mode)
- data_out  out  FIFO_WIDTH  read data
- valid_out  out  1  data_out valid
- wr_ack  out  1  registered: previous-cycle write accepted
- overflow  out  1  registered: previous-cycle write rejected
- underflow  out  1  registered: previous-cycle read rejected
- full, empty, almostfull, almostempty  out  1 each  status flags
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- Storage: FIFO_DEPTH × FIFO_WIDTH array; wr_ptr, rd_ptr each wrap FIFO_DEPTH-1 → 0 (explicit compare, not modulo-2^n).
- Write accepted iff wr_en && (!full || read accepted same cycle). Accepted write stores data_in at wr_ptr, advances wr_ptr.
- Read accepted iff rd_en && !empty. Accepted read advances rd_ptr.
- Full + wr_en + rd_en: both accepted, count unchanged. Empty + wr_en + rd_en: write accepted, read rejected (underflow=1 next cycle), count +1.
- count: +1 write only, −1 read only, unchanged for both/neither. Never exceeds FIFO_DEPTH, never negative.
- Flags combinational from count: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count ≥ AF_THRESH) && !full; almostempty = (count ≤ AE_THRESH) && !empty.
- wr_ack/overflow/underflow: one-cycle pulses registered from the accept/reject decision; wr_ack and overflow mutually exclusive; all 0 when wr_en/rd_en low.
- flush=1: pointers and count → 0, wr_en/rd_en of that cycle ignored, wr_ack/overflow/underflow/valid_out → 0 next cycle; data_out holds; memory contents not cleared.
- rst=1: same as flush plus data_out → 0. Reset values: data_out 0, valid_out 0, wr_ack 0, overflow 0, underflow 0, count 0, empty 1, full/almostfull/almostempty 0.
- rst or flush asserted mid-burst discards all in-flight entries; no partial writes.

## Timing
- Write at edge N: count, flags reflect it after edge N; wr_ack high for cycle N+1.
- Standard mode: read accepted at edge N → data_out registered at edge N, valid_out high one cycle; data_out holds between reads. Read latency 1.
- Rejected read: data_out holds, valid_out 0, underflow high one cycle.
- Write-to-readable latency: 1 cycle (entry readable the cycle after its write edge).
- No combinational path from wr_en/rd_en to any output except (FWFT) none; flags depend only on registered count.

## Configuration
- FIFO_FWFT_EN defined: data_out = mem[rd_ptr] (head shown without request), valid_out = !empty; rd_en pops the displayed word; data_out undefined-but-stable value when empty is not required, valid_out=0 marks it. Underflow rules unchanged. Head visible the cycle after its write edge.
- FIFO_FWFT_EN undefined: standard registered-read behaviour above.

## Test plan
- rst pulse, then idle → count=0, empty=1, all pulses 0, data_out=0.
- FIFO_DEPTH=6 (non-power-of-2): write 1..6 → full=1 after 6th; 7th write → overflow=1, wr_ack=0; read 6 → data_out 1..6 in order, empty=1; repeat twice to exercise pointer wrap.
- AF_THRESH=5, AE_THRESH=2, depth 8: fill 0→8 → almostempty at count 1–2, almostfull at count 5–7, both 0 at count 8.
- Full with wr_en=rd_en=1, data_in=0xA5A5 → count stays 8, wr_ack=1, head popped, 0xA5A5 read last; empty with both → count 1, underflow=1.
- Fill 4 words, assert flush with wr_en=1 → count=0, empty=1, wr_ack=0; next write 0x0042 then read → data_out=0x0042.
- With FIFO_FWFT_EN: write 0x1234 → next cycle data_out=0x1234, valid_out=1 without rd_en; rd_en → empty=1, valid_out=0.
